// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: state encoding, BCD digit
// limits, MM:SS packing and the load saturation helper.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int MMSS_W  = 16;

  localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
  localparam logic [3:0] DIGIT_MAX_TENS  = 4'd5;

  // Bit positions of each digit inside the packed {m_tens, m_units, s_tens, s_units} word
  localparam int M_TENS_LSB  = 12;
  localparam int M_UNITS_LSB = 8;
  localparam int S_TENS_LSB  = 4;
  localparam int S_UNITS_LSB = 0;

  localparam logic [15:0] MMSS_ZERO = 16'h0000;
  localparam logic [15:0] MMSS_ONE  = 16'h0001;

  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max);
    logic [3:0] r;
    if (d > max) begin
      r = max;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_mmss(input logic [15:0] v);
    logic [15:0] r;
    r = MMSS_ZERO;
    r[M_TENS_LSB  +: DIGIT_W] = sat_digit(v[M_TENS_LSB  +: DIGIT_W], DIGIT_MAX_TENS);
    r[M_UNITS_LSB +: DIGIT_W] = sat_digit(v[M_UNITS_LSB +: DIGIT_W], DIGIT_MAX_UNITS);
    r[S_TENS_LSB  +: DIGIT_W] = sat_digit(v[S_TENS_LSB  +: DIGIT_W], DIGIT_MAX_TENS);
    r[S_UNITS_LSB +: DIGIT_W] = sat_digit(v[S_UNITS_LSB +: DIGIT_W], DIGIT_MAX_UNITS);
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_dec_digit.sv
// Combinational single-digit BCD decrementer with borrow; MAX is the value the
// digit wraps to when borrowing through zero (9 for units, 5 for tens).
module bcd_dec_digit
  import countdown_timer_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX_UNITS
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  // Wrap to MAX and pass the borrow on when decrementing through zero
  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
        borrow_out = 1'b0;
      end
    end else begin
      digit_next = digit;
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with IDLE/RUNNING/PAUSED/DONE control.
// Optional internal tick prescaler enabled by defining COUNTDOWN_PRESCALER_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLKS_PER_TICK = 100000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        done_pulse
);

  state_t      state_r, state_n;
  logic [15:0] digits_r, digits_n;
  logic        running_r, done_r, done_pulse_r, done_pulse_n;
  logic        tick_eff_s;

  logic [15:0] dec_val_s;
  logic        borrow_su_s, borrow_st_s, borrow_mu_s, underflow_s;

`ifdef COUNTDOWN_PRESCALER_EN
  localparam int PRESC_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_TICK - 1);

  logic [PRESC_W-1:0] presc_cnt_r;

  // Held at zero outside RUNNING so every entry to RUNNING starts a full tick period
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_cnt_r <= {PRESC_W{1'b0}};
    end else if ((state_r != ST_RUNNING) || (presc_cnt_r == PRESC_LAST)) begin
      presc_cnt_r <= {PRESC_W{1'b0}};
    end else begin
      presc_cnt_r <= presc_cnt_r + PRESC_W'(1);
    end
  end

  assign tick_eff_s = (state_r == ST_RUNNING) && (presc_cnt_r == PRESC_LAST);
`else
  localparam bit TICK_CFG_OK = (CLKS_PER_TICK > 0);

  assign tick_eff_s = tick & TICK_CFG_OK;
`endif

  bcd_dec_digit #(.MAX(DIGIT_MAX_UNITS)) u_dec_s_units (
    .digit      (digits_r[S_UNITS_LSB +: DIGIT_W]),
    .borrow_in  (1'b1),
    .digit_next (dec_val_s[S_UNITS_LSB +: DIGIT_W]),
    .borrow_out (borrow_su_s)
  );

  bcd_dec_digit #(.MAX(DIGIT_MAX_TENS)) u_dec_s_tens (
    .digit      (digits_r[S_TENS_LSB +: DIGIT_W]),
    .borrow_in  (borrow_su_s),
    .digit_next (dec_val_s[S_TENS_LSB +: DIGIT_W]),
    .borrow_out (borrow_st_s)
  );

  bcd_dec_digit #(.MAX(DIGIT_MAX_UNITS)) u_dec_m_units (
    .digit      (digits_r[M_UNITS_LSB +: DIGIT_W]),
    .borrow_in  (borrow_st_s),
    .digit_next (dec_val_s[M_UNITS_LSB +: DIGIT_W]),
    .borrow_out (borrow_mu_s)
  );

  bcd_dec_digit #(.MAX(DIGIT_MAX_TENS)) u_dec_m_tens (
    .digit      (digits_r[M_TENS_LSB +: DIGIT_W]),
    .borrow_in  (borrow_mu_s),
    .digit_next (dec_val_s[M_TENS_LSB +: DIGIT_W]),
    .borrow_out (underflow_s)
  );

  // Next state / next digits; priority is clear > load > start_stop > tick
  always_comb begin
    state_n      = state_r;
    digits_n     = digits_r;
    done_pulse_n = 1'b0;
    if (clear) begin
      state_n  = ST_IDLE;
      digits_n = MMSS_ZERO;
    end else if (load && (state_r != ST_RUNNING)) begin
      state_n  = ST_IDLE;
      digits_n = sat_mmss(load_val);
    end else if (start_stop) begin
      case (state_r)
        ST_IDLE: begin
          if (digits_r != MMSS_ZERO) begin
            state_n = ST_RUNNING;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_RUNNING: state_n = ST_PAUSED;
        ST_PAUSED:  state_n = ST_RUNNING;
        ST_DONE:    state_n = ST_DONE;
        default:    state_n = ST_IDLE;
      endcase
    end else if (tick_eff_s && (state_r == ST_RUNNING)) begin
      // Reaching zero (or an underflowing borrow, which should not occur) ends the count
      if ((digits_r == MMSS_ONE) || underflow_s) begin
        state_n      = ST_DONE;
        digits_n     = MMSS_ZERO;
        done_pulse_n = 1'b1;
      end else begin
        digits_n = dec_val_s;
      end
    end else begin
      state_n  = state_r;
      digits_n = digits_r;
    end
  end

  // State, digit and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      digits_r     <= MMSS_ZERO;
      running_r    <= 1'b0;
      done_r       <= 1'b0;
      done_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      digits_r     <= digits_n;
      running_r    <= (state_n == ST_RUNNING);
      done_r       <= (state_n == ST_DONE);
      done_pulse_r <= done_pulse_n;
    end
  end

  assign digits     = digits_r;
  assign running    = running_r;
  assign done       = done_r;
  assign done_pulse = done_pulse_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default build, external tick).
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tick;
  logic        load;
  logic [15:0] load_val;
  logic        start_stop;
  logic        clear;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        done_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  countdown_timer #(.CLKS_PER_TICK(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tick       (tick),
    .load       (load),
    .load_val   (load_val),
    .start_stop (start_stop),
    .clear      (clear),
    .digits     (digits),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic r,
                         input logic dn, input logic dp);
    chk({tag, ".digits"}, digits, d);
    chk({tag, ".running"}, {15'd0, running}, {15'd0, r});
    chk({tag, ".done"}, {15'd0, done}, {15'd0, dn});
    chk({tag, ".done_pulse"}, {15'd0, done_pulse}, {15'd0, dp});
  endtask

  // One clock with the given pulses applied; outputs sampled 1 time unit after the edge
  task automatic cyc(input logic ld, input logic [15:0] lv, input logic ss,
                     input logic clr, input logic tk);
    load = ld; load_val = lv; start_stop = ss; clear = clr; tick = tk;
    @(posedge clk);
    #1;
    load = 1'b0; load_val = 16'h0000; start_stop = 1'b0; clear = 1'b0; tick = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; load = 1'b0; load_val = 16'h0000;
    start_stop = 1'b0; clear = 1'b0;
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;

    // 00:03 counted down to done
    cyc(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    chk_out("load3", 16'h0003, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_out("start3", 16'h0003, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("tick1", 16'h0002, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("tick2", 16'h0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("tick3", 16'h0000, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_out("done_hold", 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("done_tick", 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_out("done_ss", 16'h0000, 1'b0, 1'b1, 1'b0);

    // 10:00 borrows through every digit
    cyc(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    chk_out("load1000", 16'h1000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("borrow_chain", 16'h0959, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk_out("clear_run", 16'h0000, 1'b0, 1'b0, 1'b0);

    // 00:10 borrows only from s_tens
    cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("idle_tick", 16'h0010, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("s_borrow", 16'h0009, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Saturating load
    cyc(1'b1, 16'h9A7F, 1'b0, 1'b0, 1'b0);
    chk_out("sat_load", 16'h5959, 1'b0, 1'b0, 1'b0);

    // Zero load cannot start
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_out("zero_start", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Pause beats tick; paused ignores tick; resume
    cyc(1'b1, 16'h0105, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_out("run105", 16'h0105, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk_out("pause_wins", 16'h0105, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("paused_tick", 16'h0105, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_out("resume", 16'h0105, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("resume_tick", 16'h0104, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0);
    chk_out("load_in_run", 16'h0104, 1'b1, 1'b0, 1'b0);

    // Clear beats load
    cyc(1'b1, 16'h0200, 1'b0, 1'b1, 1'b0);
    chk_out("clear_load", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-count, on the very edge that would reach zero
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("pre_reset", 16'h0001, 1'b1, 1'b0, 1'b0);
    resetn = 1'b0;
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_out("post_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
